// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: formats stores, extends loads,
// and runs one req/ack transaction at a time on the data bus.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_EXC
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      ldata_q, ldata_d;
  logic [1:0]       exc_q, exc_d;

  logic        illegal;
  logic        misal;
  logic        accept;
  logic        tmo_hit;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ext;

  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    if (req_write) begin
      illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    end else begin
      illegal = (req_funct3[1:0] == 2'b11)
              | (req_funct3 == 3'b110);
    end
    unique case (1'b1)
      req_funct3[1:0] == 2'b01: misal = req_addr[0];
      req_funct3[1:0] == 2'b10: misal = |req_addr[1:0];
      default:                  misal = 1'b0;
    endcase
  end

  // Byte/half store data is replicated across lanes; be picks the lane.
  always_comb begin
    fmt_wdata = '0;
    fmt_be    = 4'hF;
    if (req_write) begin
      unique case (1'b1)
        req_funct3[1:0] == 2'b00: begin
          fmt_wdata = {4{req_wdata[7:0]}};
          fmt_be    = 4'b0001 << req_addr[1:0];
        end
        req_funct3[1:0] == 2'b01: begin
          fmt_wdata = {2{req_wdata[15:0]}};
          fmt_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          fmt_wdata = req_wdata;
          fmt_be    = 4'hF;
        end
      endcase
    end
  end

  always_comb begin
    bsel = mem_rdata[{off_q, 3'b000} +: 8];
    hsel = mem_rdata[{off_q[1], 4'b0000} +: 16];
    unique case (1'b1)
      f3_q == 3'b000: ext = {{24{bsel[7]}}, bsel};
      f3_q == 3'b001: ext = {{16{hsel[15]}}, hsel};
      f3_q == 3'b100: ext = {24'd0, bsel};
      f3_q == 3'b101: ext = {16'd0, hsel};
      default:        ext = mem_rdata;
    endcase
  end

  assign accept  = (state_q == S_IDLE) & req_valid
                 & ~illegal & ~misal;
  assign cnt_inc = cnt_q + 1'b1;
  assign tmo_hit = (TIMEOUT_CYCLES != 0)
                 && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ldata_d = ldata_q;
    exc_d   = exc_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            exc_d   = 2'b10;
            state_d = S_EXC;
          end else if (misal) begin
            exc_d   = 2'b01;
            state_d = S_EXC;
          end else begin
            we_d    = req_write;
            f3_d    = req_funct3;
            off_d   = req_addr[1:0];
            addr_d  = {req_addr[31:2], 2'b00};
            wdata_d = fmt_wdata;
            be_d    = fmt_be;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // An ack in the timeout cycle still completes the access.
        if (mem_ack) begin
          if (!we_q) ldata_d = ext;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (tmo_hit) begin
            exc_d   = 2'b11;
            state_d = S_EXC;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'h0;
      ldata_q <= '0;
      exc_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ldata_q <= ldata_d;
      exc_q   <= exc_d;
    end
  end

  assign busy       = rst_n & ((state_q == S_WAIT) | accept);
  assign mem_req    = (state_q == S_WAIT);
  assign mem_we     = we_q & mem_req;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign load_valid = (state_q == S_RESP) & ~we_q;
  assign load_data  = ldata_q;
  assign exc_valid  = (state_q == S_EXC);
  assign exc_code   = exc_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: random and directed
// loads/stores against a byte-level reference model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, load_valid, exc_valid;
  logic [31:0] load_data;
  logic [1:0]  exc_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy),
    .load_valid(load_valid), .load_data(load_data),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // kind: 0 load done, 1 store done, 2 exception
  typedef struct {
    int          kind;
    logic        bus;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] ldata;
    logic [1:0]  code;
  } exp_t;

  exp_t        q[$];
  int          nchk = 0;
  int          nbad = 0;
  int          ack_delay = 0;
  logic [31:0] rdata_v = '0;
  int          wcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    nchk++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic bad(input string nm);
    nchk++;
    nbad++;
    $display("FAIL %s got=unexpected want=none", nm);
  endtask

  // Bus responder: ack in the ack_delay-th cycle of mem_req.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        wcnt++;
        mem_ack   = (wcnt == ack_delay);
        mem_rdata = (wcnt == ack_delay) ? rdata_v : $urandom;
      end else begin
        wcnt      = 0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (q.size() == 0 || !q[0].bus) begin
          bad("mem_req");
        end else begin
          chk("mem_addr", mem_addr, q[0].addr);
          chk("mem_we", 32'(mem_we), 32'(q[0].we));
          chk("mem_be", 32'(mem_be), 32'(q[0].be));
          chk("mem_wdata", mem_wdata, q[0].wdata);
          if (mem_ack && q[0].kind == 1) void'(q.pop_front());
        end
      end
      if (load_valid) begin
        if (q.size() == 0 || q[0].kind != 0) begin
          bad("load_valid");
        end else begin
          chk("load_data", load_data, q[0].ldata);
          void'(q.pop_front());
        end
      end
      if (exc_valid) begin
        if (q.size() == 0 || q[0].kind != 2) begin
          bad("exc_valid");
        end else begin
          chk("exc_code", 32'(exc_code), 32'(q[0].code));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int d);
    exp_t        e;
    logic        ill, mis;
    int          off, expn, n;
    logic [31:0] bt, hf;
    off     = int'(a[1:0]);
    e.kind  = 2;
    e.bus   = 1'b0;
    e.we    = 1'b0;
    e.addr  = '0;
    e.wdata = '0;
    e.be    = '0;
    e.ldata = '0;
    e.code  = 2'b00;
    if (w) ill = (f > 3'd2);
    else   ill = !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = (f[1:0] == 2'd1 && (a % 2) != 0)
       || (f[1:0] == 2'd2 && (a % 4) != 0);
    if (ill) begin
      e.code = 2'b10;
      expn   = 1;
    end else if (mis) begin
      e.code = 2'b01;
      expn   = 1;
    end else begin
      e.bus  = 1'b1;
      e.we   = w;
      e.addr = a & 32'hFFFF_FFFC;
      if (!w) begin
        e.be    = 4'hF;
        e.wdata = '0;
      end else if (f == 3'd0) begin
        e.wdata = wd[7:0] * 32'h0101_0101;
        e.be    = 4'(1 << off);
      end else if (f == 3'd1) begin
        e.wdata = wd[15:0] * 32'h0001_0001;
        e.be    = (off >= 2) ? 4'hC : 4'h3;
      end else begin
        e.wdata = wd;
        e.be    = 4'hF;
      end
      if (d < 1 || d > TO) begin
        e.code = 2'b11;
        expn   = TO + 1;
      end else if (w) begin
        e.kind = 1;
        expn   = d;
      end else begin
        e.kind = 0;
        expn   = d + 1;
        bt = (rd >> (8 * off)) & 32'hFF;
        hf = (rd >> (16 * (off / 2))) & 32'hFFFF;
        case (f)
          3'd0:    e.ldata = bt[7] ? (bt | 32'hFFFF_FF00) : bt;
          3'd1:    e.ldata = hf[15] ? (hf | 32'hFFFF_0000) : hf;
          3'd4:    e.ldata = bt;
          3'd5:    e.ldata = hf;
          default: e.ldata = rd;
        endcase
      end
    end
    ack_delay = d;
    rdata_v   = rd;
    q.push_back(e);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    chk("busy_accept", 32'(busy), 32'(e.bus));
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      bad("response_timeout");
      q.delete();
    end else begin
      chk("latency", 32'(n), 32'(expn));
    end
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w;
    logic [2:0]  f;
    int          d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_flags", {mem_be, mem_we, load_valid, exc_valid,
                      exc_code}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 3);
    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1);
    issue(1'b1, 3'b000, 32'h0000_0006, 32'h1234_56AB, 32'h0, 2);
    issue(1'b1, 3'b001, 32'h0000_000A, 32'h0000_C0DE, 32'h0, 1);
    issue(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 1);
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1);
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h5555_5555, 32'h0, 1);
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1111_2222, 0);
    issue(1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, TO);
    issue(1'b1, 3'b010, 32'h0000_0208, 32'hDEAD_BEEF, 32'h0, 0);

    for (int i = 0; i < 250; i++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      if (w && f == 3'd3) f = 3'd2;
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO + 1);
      issue(w, f, $urandom, $urandom, $urandom, d);
    end

    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h7654_3210, 1);
    ack_delay = 0;
    q.push_back('{2, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF,
                  32'h0, 2'b11});
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0040;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wait_mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_load_data", load_data, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 3'b100, 32'h0000_0051, 32'h0, 32'h0000_9A00, 2);
    if (q.size() != 0) bad("queue_leftover");
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
